// File: rtl/bcd_pkg.sv
// Shared constants and types for the serial packed-BCD adder.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_DONE
    } state_t;

    // True when the nibble is a legal decimal digit.
    function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add cell: binary add of two nibbles plus carry-in, with the
// +6 decimal correction whenever the raw sum exceeds nine.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_i,
    input  logic [BCD_DIGIT_W-1:0] b_i,
    input  logic                   cin_i,
    output logic [BCD_DIGIT_W-1:0] s_o,
    output logic                   cout_o
);

    // Raw sum reaches at most 15+15+1 = 31, so six bits hold it plus correction.
    logic [5:0] t_raw;
    logic [5:0] t_corr;

    // Raw add, then decimal correction of the low nibble.
    always_comb begin
        t_raw  = {2'b00, a_i} + {2'b00, b_i} + {5'b00000, cin_i};
        t_corr = t_raw;
        cout_o = 1'b0;
        if (t_raw > {2'b00, BCD_MAX}) begin
            t_corr = t_raw + {2'b00, BCD_CORR};
            cout_o = 1'b1;
        end
        s_o = t_corr[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder: one digit per clock through a single digit
// cell, decimal carry held between digits, valid/ready on both sides.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          carry_out,
    output logic                          invalid
);

    localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             inv_q, inv_d;

    logic [BCD_DIGIT_W-1:0] dig_a;
    logic [BCD_DIGIT_W-1:0] dig_b;
    logic [BCD_DIGIT_W-1:0] dig_s;
    logic                   dig_cout;

    // Select the operand digits addressed by the index counter.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_a = a_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
                dig_b = b_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
        end
    end

    bcd_digit_add u_digit (
        .a_i    (dig_a),
        .b_i    (dig_b),
        .cin_i  (carry_q),
        .s_o    (dig_s),
        .cout_o (dig_cout)
    );

    // Next-state logic: accept, step one digit per cycle, then hold the result.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    inv_d   = 1'b0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dig_s;
                    end
                end
                carry_d = dig_cout;
                inv_d   = inv_q | ~is_bcd_digit(dig_a) | ~is_bcd_digit(dig_b);
                if (idx_q == LAST_IDX) begin
                    // Index parks at zero so it never exceeds the top digit.
                    idx_d   = '0;
                    cout_d  = dig_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4) against a decimal model.
module tb_bcd_serial_adder;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         invalid;

    int checks = 0;
    int errors = 0;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal arithmetic for legal operands; the per-digit
    // add-and-correct rule only when some digit is out of range.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [W-1:0] ms, output logic mc,
                                  output logic mi);
        logic [3:0] da, db;
        int va, vb, tot, lim, t, c;
        bit ok;
        ok = 1'b1;
        va = 0;
        vb = 0;
        lim = 1;
        ms = '0;
        for (int i = D - 1; i >= 0; i--) begin
            da = ma[i*4 +: 4];
            db = mb[i*4 +: 4];
            if (da > 9 || db > 9) ok = 1'b0;
            va = va * 10 + int'(da);
            vb = vb * 10 + int'(db);
            lim = lim * 10;
        end
        mi = !ok;
        if (ok) begin
            tot = va + vb;
            mc  = (tot >= lim);
            tot = tot % lim;
            for (int i = 0; i < D; i++) begin
                ms[i*4 +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = 0;
            for (int i = 0; i < D; i++) begin
                t = int'(ma[i*4 +: 4]) + int'(mb[i*4 +: 4]) + c;
                if (t > 9) begin
                    t = t + 6;
                    c = 1;
                end else begin
                    c = 0;
                end
                ms[i*4 +: 4] = 4'(t % 16);
            end
            mc = (c != 0);
        end
    endfunction

    function automatic logic [W-1:0] rand_operand(input int bad_pct);
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) begin
            if (int'($urandom_range(0, 99)) < bad_pct)
                v[i*4 +: 4] = 4'($urandom_range(10, 15));
            else
                v[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Present one operand pair and return just after its accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        a = ta;
        b = tb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Count edges after acceptance until out_valid is seen (bounded).
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 50) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid) break;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL result_timeout out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #12;
        checks++;
        if ({in_ready, out_valid, sum, carry_out, invalid} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b sum=%h co=%b inv=%b required 1 0 0000 0 0",
                     in_ready, out_valid, sum, carry_out, invalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        send(16'h1234, 16'h5678);
        wait_valid(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL basic_latency got %0d required 4", cyc);
        end
        checks++;
        if ({sum, carry_out, invalid} !== {16'h6912, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result got %h/%b/%b required 6912/0/0", sum, carry_out, invalid);
        end
        consume();
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_release got vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_ripple();
        int cyc;
        send(16'h9999, 16'h0001);
        wait_valid(cyc);
        checks++;
        if ({sum, carry_out, invalid} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ripple_result got %h/%b/%b required 0000/1/0", sum, carry_out, invalid);
        end
        consume();
        send(16'h9999, 16'h9999);
        wait_valid(cyc);
        checks++;
        if ({sum, carry_out} !== {16'h9998, 1'b1}) begin
            errors++;
            $display("FAIL max_result got %h/%b required 9998/1", sum, carry_out);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int cyc;
        send(16'h0500, 16'h0500);
        wait_valid(cyc);
        // Busy-time input must be ignored.
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, sum, carry_out} !== {1'b1, 1'b0, 16'h1000, 1'b0}) begin
                errors++;
                $display("FAIL hold_cycle%0d got vld=%b rdy=%b sum=%h co=%b required 1 0 1000 0",
                         i, out_valid, in_ready, sum, carry_out);
            end
        end
        in_valid = 1'b0;
        consume();
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release got vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_invalid();
        int cyc;
        send(16'h00A3, 16'h0001);
        wait_valid(cyc);
        checks++;
        if ({sum, carry_out, invalid} !== {16'h0104, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL invalid_result got %h/%b/%b required 0104/0/1", sum, carry_out, invalid);
        end
        consume();
        // A following legal op must clear the flag.
        send(16'h0002, 16'h0003);
        wait_valid(cyc);
        checks++;
        if ({sum, invalid} !== {16'h0005, 1'b0}) begin
            errors++;
            $display("FAIL invalid_clear got %h/%b required 0005/0", sum, invalid);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int cyc;
        send(16'h4321, 16'h1111);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, sum, carry_out, invalid} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_state got rdy=%b vld=%b sum=%h co=%b inv=%b required 1 0 0000 0 0",
                     in_ready, out_valid, sum, carry_out, invalid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0001, 16'h0002);
        wait_valid(cyc);
        checks++;
        if ({sum, carry_out, invalid} !== {16'h0003, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_next got %h/%b/%b required 0003/0/0", sum, carry_out, invalid);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] es1, es2;
        logic ec1, ec2, ei1, ei2;
        logic [W-1:0] a1, b1, a2, b2;
        a1 = rand_operand(0);
        b1 = rand_operand(0);
        a2 = rand_operand(0);
        b2 = rand_operand(0);
        model(a1, b1, es1, ec1, ei1);
        model(a2, b2, es2, ec2, ei2);
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = a1;
        b = b1;
        @(posedge clk);
        #1;
        a = a2;
        b = b2;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 6) in_valid = 1'b0;
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if ({out_valid, sum, carry_out} !== {1'b1, es1, ec1}) begin
                    errors++;
                    $display("FAIL b2b_first got vld=%b sum=%h co=%b required 1 %h %b",
                             out_valid, sum, carry_out, es1, ec1);
                end
            end else if (c == 5) begin
                checks++;
                if ({out_valid, in_ready} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_gap got vld=%b rdy=%b required 0 1", out_valid, in_ready);
                end
            end else if (c == 6) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_accept2 got rdy=%b required 0", in_ready);
                end
            end else if (c == 10) begin
                checks++;
                if ({out_valid, sum, carry_out} !== {1'b1, es2, ec2}) begin
                    errors++;
                    $display("FAIL b2b_second got vld=%b sum=%h co=%b required 1 %h %b",
                             out_valid, sum, carry_out, es2, ec2);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy_c%0d got vld=%b required 0", c, out_valid);
                end
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int cyc;
        int wait_n;
        logic [W-1:0] ra, rb, es;
        logic ec, ei;
        for (int n = 0; n < 40; n++) begin
            ra = rand_operand(8);
            rb = rand_operand(8);
            model(ra, rb, es, ec, ei);
            send(ra, rb);
            wait_valid(cyc);
            checks++;
            if ({cyc, sum, carry_out, invalid} !== {32'd4, es, ec, ei}) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h got lat=%0d %h/%b/%b required 4 %h/%b/%b",
                         n, ra, rb, cyc, sum, carry_out, invalid, es, ec, ei);
            end
            wait_n = int'($urandom_range(0, 3));
            for (int k = 0; k < wait_n; k++) @(negedge clk);
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_invalid();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
